// File: rtl/instr_exec_ctrl.sv
// Start/Ready instruction responder for the panel-to-micro handshake.
// Latches and decodes one instruction, waits on the ALU, writes, retires.
module instr_exec_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int ADDR_W  = 4,
  parameter int OP_W    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [OP_W-1:0]   OpCode,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [ADDR_W-1:0] AddrC,
  output logic              Ready,
  output logic              Wen,
  output logic              IsImm,
  output logic [3:0]        OpALU,
  output logic [ADDR_W-1:0] AddrAQ,
  output logic [ADDR_W-1:0] AddrBQ,
  output logic [ADDR_W-1:0] AddrCQ,
  output logic              Done,
  output logic [15:0]       InstrCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_EXEC,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state;
  logic       start_q;
  logic       nop_q;
  logic [3:0] cnt;
  logic       accept;
  logic       dec_imm;
  logic       dec_nop;
  logic [3:0] dec_alu;

  assign accept = (state == S_IDLE) & Start & ~start_q;

  // Opcode decode: all-ones is a NOP, upper half uses the immediate
  always_comb begin
    dec_imm = 1'b0;
    dec_nop = 1'b0;
    dec_alu = {1'b0, OpCode[2:0]};
    unique case (1'b1)
      (&OpCode): begin
        dec_nop = 1'b1;
        dec_alu = 4'h0;
      end
      (OpCode[3] && !(&OpCode)): dec_imm = 1'b1;
      (!OpCode[3]): dec_imm = 1'b0;
    endcase
  end

  // Handshake FSM with registered datapath controls
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      start_q  <= 1'b1;
      nop_q    <= 1'b0;
      cnt      <= '0;
      Ready    <= 1'b1;
      Wen      <= 1'b0;
      Done     <= 1'b0;
      IsImm    <= 1'b0;
      OpALU    <= '0;
      AddrAQ   <= '0;
      AddrBQ   <= '0;
      AddrCQ   <= '0;
      InstrCnt <= '0;
    end else begin
      start_q <= Start;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            AddrAQ <= AddrA;
            AddrBQ <= AddrB;
            AddrCQ <= AddrC;
            IsImm  <= dec_imm;
            OpALU  <= dec_alu;
            nop_q  <= dec_nop;
            Ready  <= 1'b0;
            state  <= S_DEC;
          end
        end
        S_DEC: begin
          cnt   <= LAT_M1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (cnt == 4'd0) begin
            Wen   <= ~nop_q;
            state <= S_WR;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WR: begin
          Wen      <= 1'b0;
          Done     <= 1'b1;
          InstrCnt <= InstrCnt + 16'd1;
          state    <= S_DONE;
        end
        S_DONE: begin
          Done  <= 1'b0;
          Ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          Wen   <= 1'b0;
          Done  <= 1'b0;
          Ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
